// File: rtl/channel_stat_broadcast_if.sv
// Stream bundle for channel_stat_broadcast.
//   Input stream : in_data / in_valid / in_ready  (one statistic word per channel)
//   Output stream: out_data / out_valid / out_ready plus beat tags
//                  out_channel, out_spatial, out_last_spatial, out_last_frame
// Modports:
//   slave  - the broadcast block (consumes the input stream, drives the output stream)
//   master - the surrounding logic or a test environment
interface channel_stat_broadcast_if #(
  parameter int DATA_WIDTH = 16,
  parameter int C_W        = 1,
  parameter int S_W        = 2
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [C_W-1:0]        out_channel;
  logic [S_W-1:0]        out_spatial;
  logic                  out_last_spatial;
  logic                  out_last_frame;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_channel, out_spatial,
           out_last_spatial, out_last_frame
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_channel, out_spatial,
           out_last_spatial, out_last_frame
  );
endinterface

// File: rtl/channel_stat_broadcast.sv
// channel_stat_broadcast
//   Read side of the per-channel statistics path. Buffers one statistic word per
//   channel in a small FIFO and replays the head word once per spatial block,
//   channel outer / spatial block inner, tagging each beat with its indices and
//   frame boundaries.
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous reset, active-low
//   flush       synchronous clear of buffer and counters (dominates push/pop)
//   bus         channel_stat_broadcast_if.slave (input stream, output stream, tags)
//   stall_count cycles with out_valid && !out_ready, saturating
//               (only when CHANNEL_STAT_BCAST_STALL_CNT_EN is defined)
// Build option: CHANNEL_STAT_BCAST_STALL_CNT_EN adds the stall counter port.
module channel_stat_broadcast #(
  parameter int DATA_WIDTH         = 16,
  parameter int NUM_CHANNELS       = 2,
  parameter int NUM_SPATIAL_BLOCKS = 4,
  parameter int BUF_DEPTH          = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  channel_stat_broadcast_if.slave     bus
`ifdef CHANNEL_STAT_BCAST_STALL_CNT_EN
  ,
  output logic [31:0]                 stall_count
`endif
);

  localparam int C_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int S_W = (NUM_SPATIAL_BLOCKS > 1) ? $clog2(NUM_SPATIAL_BLOCKS) : 1;
  localparam int P_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int N_W = $clog2(BUF_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [P_W-1:0]        wr_ptr, rd_ptr;
  logic [N_W-1:0]        count;
  logic [C_W-1:0]        channel;
  logic [S_W-1:0]        spatial;
  logic                  live;   // low during reset and for the first cycle after release
  logic                  empty, full, push, beat, pop, last_sp, last_ch;

  function automatic logic [P_W-1:0] ptr_next(input logic [P_W-1:0] p);
    return (p == P_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty   = (count == '0);
    full    = (count == N_W'(BUF_DEPTH));
    last_sp = (spatial == S_W'(NUM_SPATIAL_BLOCKS - 1));
    last_ch = (channel == C_W'(NUM_CHANNELS - 1));

    // in_ready looks only at the current occupancy: a pop this cycle does not
    // make room for a push until the next cycle.
    bus.in_ready = live && !full && !flush;
    push         = bus.in_valid && bus.in_ready;
    beat         = !empty && bus.out_ready && !flush;
    pop          = beat && last_sp;

    bus.out_valid        = !empty;
    bus.out_data         = empty ? '0 : mem[rd_ptr];
    bus.out_channel      = (NUM_CHANNELS == 1) ? '0 : channel;
    bus.out_spatial      = (NUM_SPATIAL_BLOCKS == 1) ? '0 : spatial;
    bus.out_last_spatial = last_sp;
    bus.out_last_frame   = last_sp && last_ch;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live    <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      channel <= '0;
      spatial <= '0;
    end else begin
      live <= 1'b1;
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        channel <= '0;
        spatial <= '0;
      end else begin
        if (push) wr_ptr <= ptr_next(wr_ptr);
        if (pop)  rd_ptr <= ptr_next(rd_ptr);
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (beat) begin
          if (last_sp) begin
            spatial <= '0;
            channel <= last_ch ? '0 : channel + 1'b1;
          end else begin
            spatial <= spatial + 1'b1;
          end
        end
      end
    end
  end

`ifdef CHANNEL_STAT_BCAST_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (flush) begin
      stall_count <= '0;
    end else if (!empty && !bus.out_ready && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_channel_stat_broadcast.sv
// Self-checking bench for channel_stat_broadcast.
// Instance A (NC=2, NSB=4, depth 4) is checked every cycle against a queue-based
// model; instance B (NC=1, NSB=1) gets literal checks only.
module tb_channel_stat_broadcast;

  localparam int DW    = 16;
  localparam int NC    = 2;
  localparam int NSB   = 4;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush_a = 1'b0;
  logic flush_b = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  channel_stat_broadcast_if #(.DATA_WIDTH(DW), .C_W(1), .S_W(2)) ia ();
  channel_stat_broadcast_if #(.DATA_WIDTH(DW), .C_W(1), .S_W(1)) ib ();

`ifdef CHANNEL_STAT_BCAST_STALL_CNT_EN
  logic [31:0] stall_a, stall_b;
`endif

  channel_stat_broadcast #(
    .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .NUM_SPATIAL_BLOCKS(NSB), .BUF_DEPTH(DEPTH)
  ) dut_a (
    .clk(clk), .rst(rst_n), .flush(flush_a), .bus(ia.slave)
`ifdef CHANNEL_STAT_BCAST_STALL_CNT_EN
    , .stall_count(stall_a)
`endif
  );

  channel_stat_broadcast #(
    .DATA_WIDTH(DW), .NUM_CHANNELS(1), .NUM_SPATIAL_BLOCKS(1), .BUF_DEPTH(DEPTH)
  ) dut_b (
    .clk(clk), .rst(rst_n), .flush(flush_b), .bus(ib.slave)
`ifdef CHANNEL_STAT_BCAST_STALL_CNT_EN
    , .stall_count(stall_b)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- behavioural model of instance A ----------------
  // Stored words in a queue; k = beats taken in the current frame.
  // Channel = k / NSB, spatial = k % NSB.
  logic [DW-1:0] q[$];
  int            k = 0;
  bit            up = 0;
  logic [31:0]   m_stall = 0;

  always @(posedge clk or negedge rst_n) begin : model
    bit beat, pop, push;
    if (!rst_n) begin
      q.delete(); k = 0; up = 0; m_stall = 0;
    end else if (flush_a) begin
      q.delete(); k = 0; m_stall = 0; up = 1;
    end else begin
      beat = (q.size() > 0) && ia.out_ready;
      pop  = beat && ((k % NSB) == NSB - 1);
      push = ia.in_valid && up && (q.size() < DEPTH);
      if ((q.size() > 0) && !ia.out_ready && (m_stall != 32'hFFFF_FFFF)) m_stall++;
      if (beat) k = (k + 1) % (NC * NSB);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(ia.in_data);
      up = 1;
    end
  end

  always @(negedge clk) begin : compare
    int m_ch, m_sp;
    logic [31:0] m_data;
    m_sp   = k % NSB;
    m_ch   = k / NSB;
    m_data = (q.size() > 0) ? 32'(q[0]) : 32'h0;
    chk("out_valid",    32'(ia.out_valid),        32'(q.size() > 0));
    chk("out_data",     32'(ia.out_data),         m_data);
    chk("out_channel",  32'(ia.out_channel),      32'(m_ch));
    chk("out_spatial",  32'(ia.out_spatial),      32'(m_sp));
    chk("last_spatial", 32'(ia.out_last_spatial), 32'(m_sp == NSB - 1));
    chk("last_frame",   32'(ia.out_last_frame),   32'((m_sp == NSB - 1) && (m_ch == NC - 1)));
    chk("in_ready",     32'(ia.in_ready),         32'(up && (q.size() < DEPTH) && !flush_a));
`ifdef CHANNEL_STAT_BCAST_STALL_CNT_EN
    chk("stall_count",  stall_a,                  m_stall);
`endif
  end

  // beat log for the first directed test
  bit          log_en = 0;
  logic [31:0] log_q[$];
  always @(negedge clk) begin
    if (log_en && ia.out_valid && ia.out_ready)
      log_q.push_back({12'h0, ia.out_last_frame, ia.out_last_spatial,
                       1'(ia.out_channel), 2'(ia.out_spatial), ia.out_data});
  end

  task automatic pulse_flush();
    flush_a = 1'b1;
    step();
    flush_a = 1'b0;
  endtask

  initial begin
    logic [31:0] e;
    ia.in_valid = 0; ia.in_data = '0; ia.out_ready = 0;
    ib.in_valid = 0; ib.in_data = '0; ib.out_ready = 0;

    // reset state
    #2;
    chk("rst_out_valid", 32'(ia.out_valid), 0);
    chk("rst_in_ready",  32'(ia.in_ready),  0);
    chk("rst_out_data",  32'(ia.out_data),  0);
    step(2);
    rst_n = 1'b1;
    chk("rel_in_ready_low", 32'(ia.in_ready), 0);
    step();
    chk("rel_in_ready_high", 32'(ia.in_ready), 1);

    // 1: two words, always ready -> 8 beats
    log_en = 1;
    ia.out_ready = 1;
    ia.in_valid = 1; ia.in_data = 16'h0011; step();
    ia.in_data = 16'h0022; step();
    ia.in_valid = 0;
    step(10);
    log_en = 0;
    chk("t1_beats", 32'(log_q.size()), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      e = {12'h0, 1'(i == 7), 1'((i % 4) == 3), 1'(i / 4), 2'(i % 4),
           (i < 4) ? 16'h0011 : 16'h0022};
      chk($sformatf("t1_beat%0d", i), log_q[i], e);
    end

    // 2: fill with consumer stalled, then drain
    ia.out_ready = 0;
    ia.in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      ia.in_data = 16'(16'h0101 + i);
      step();
    end
    ia.in_data = 16'h0105;
    chk("t2_full_in_ready", 32'(ia.in_ready), 0);
    ia.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t2_drain_in_ready%0d", i), 32'(ia.in_ready), 32'(i == 3));
    end
    step();
    ia.in_valid = 0;
    step(20);
    chk("t2_empty", 32'(ia.out_valid), 0);

    // 3: stalls hold head and tags
    ia.out_ready = 0;
    pulse_flush();
    ia.in_valid = 1; ia.in_data = 16'h00AB; step();
    ia.in_valid = 0;
    ia.out_ready = 1; step();
    ia.out_ready = 0; step();
    chk("t3_data_stall1", 32'(ia.out_data), 32'h00AB);
    chk("t3_sp_stall1",   32'(ia.out_spatial), 1);
    step();
    chk("t3_data_stall2", 32'(ia.out_data), 32'h00AB);
    chk("t3_sp_stall2",   32'(ia.out_spatial), 1);
    ia.out_ready = 1; step();
    chk("t3_sp_after", 32'(ia.out_spatial), 2);
`ifdef CHANNEL_STAT_BCAST_STALL_CNT_EN
    chk("t3_stall_count", stall_a, 2);
`endif
    ia.out_ready = 0;
    pulse_flush();

    // 4: flush mid-frame with a coincident push
    ia.in_valid = 1; ia.in_data = 16'h00C1; step();
    ia.in_data = 16'h00C2; step();
    ia.in_valid = 0;
    ia.out_ready = 1; step(6);
    ia.out_ready = 0;
    chk("t4_pre_ch", 32'(ia.out_channel), 1);
    chk("t4_pre_sp", 32'(ia.out_spatial), 2);
    flush_a = 1; ia.in_valid = 1; ia.in_data = 16'hDEAD; ia.out_ready = 1;
    step();
    flush_a = 0; ia.in_valid = 0; ia.out_ready = 0;
    chk("t4_valid", 32'(ia.out_valid), 0);
    chk("t4_ch",    32'(ia.out_channel), 0);
    chk("t4_sp",    32'(ia.out_spatial), 0);
    step();
    chk("t4_dropped", 32'(ia.out_valid), 0);

    // 5: asynchronous reset mid-frame
    ia.in_valid = 1; ia.in_data = 16'h0555; step();
    ia.in_valid = 0; ia.out_ready = 1; step();
    ia.out_ready = 0;
    #2 rst_n = 0;
    #1;
    chk("t5_valid", 32'(ia.out_valid), 0);
    chk("t5_data",  32'(ia.out_data), 0);
    chk("t5_rdy",   32'(ia.in_ready), 0);
    chk("t5_sp",    32'(ia.out_spatial), 0);
    chk("t5_ch",    32'(ia.out_channel), 0);
    chk("t5_lsp",   32'(ia.out_last_spatial), 0);
    chk("t5_lfr",   32'(ia.out_last_frame), 0);
    step(2);
    @(negedge clk);
    #2 rst_n = 1;
    chk("t5_rdy_rel", 32'(ia.in_ready), 0);
    @(posedge clk);
    #1;
    chk("t5_rdy_up", 32'(ia.in_ready), 1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      ia.in_valid  = ($urandom_range(0, 9) < 6);
      ia.in_data   = 16'($urandom);
      ia.out_ready = ($urandom_range(0, 9) < 6);
      flush_a      = ($urandom_range(0, 49) == 0);
      step();
    end
    ia.in_valid = 0; ia.out_ready = 0; flush_a = 0;

    // 6: NC=1, NSB=1 instance, back-to-back words
    ib.out_ready = 1;
    ib.in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      ib.in_data = 16'(16'h0A01 + i);
      step();
      chk($sformatf("t6_valid%0d", i), 32'(ib.out_valid), 1);
      chk($sformatf("t6_data%0d", i),  32'(ib.out_data), 32'(16'h0A01 + i));
      chk($sformatf("t6_ch%0d", i),    32'(ib.out_channel), 0);
      chk($sformatf("t6_sp%0d", i),    32'(ib.out_spatial), 0);
      chk($sformatf("t6_lfr%0d", i),   32'(ib.out_last_frame), 1);
    end
    ib.in_valid = 0;
    step();
    chk("t6_empty", 32'(ib.out_valid), 0);
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
